// File: rtl/mem_pkg.sv
// Shared constants, op-field indices and FSM encoding for the MEM stage.
// Build option: MEM_ALIGN_CHECK_EN widens the exception side-band with an ALE bit.
package mem_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned DISCARD_MAX = 3;
    localparam int unsigned CNT_W       = 2;
    localparam int unsigned CSR_W       = 112;
`ifdef MEM_ALIGN_CHECK_EN
    localparam int unsigned EXC_W       = 3;
`else
    localparam int unsigned EXC_W       = 2;
`endif
    localparam int unsigned ALE_BIT     = EXC_W - 1;
    localparam int unsigned OP_W        = 8;
    localparam int unsigned RF_ALL_W    = 6;
    localparam int unsigned MEM_RF_W    = RF_ALL_W + DATA_W;

    // exe_mem_op = {we,ld_b,ld_h,ld_w,ld_se,st_b,st_h,st_w}
    localparam int unsigned OP_WE    = 7;
    localparam int unsigned OP_LD_B  = 6;
    localparam int unsigned OP_LD_H  = 5;
    localparam int unsigned OP_LD_W  = 4;
    localparam int unsigned OP_LD_SE = 3;
    localparam int unsigned OP_ST_B  = 2;
    localparam int unsigned OP_ST_H  = 1;
    localparam int unsigned OP_ST_W  = 0;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic size_e op_size(input logic [OP_W-1:0] op);
        if (op[OP_LD_B] | op[OP_ST_B])      return SIZE_B;
        else if (op[OP_LD_H] | op[OP_ST_H]) return SIZE_H;
        else                                return SIZE_W;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [1:0]        i_addr_lo,
    input  logic              i_ld_b,
    input  logic              i_ld_h,
    input  logic              i_ld_w,
    input  logic              i_ld_se,
    output logic [DATA_W-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = '0;
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

        o_data = '0;
        if (i_ld_b)
            o_data = {{24{i_ld_se & w_byte[7]}}, w_byte};
        else if (i_ld_h)
            o_data = {{16{i_ld_se & w_half[15]}}, w_half};
        else if (i_ld_w)
            o_data = i_rdata;
    end

endmodule

// File: rtl/mem_stage_hs.sv
// MEM pipeline stage with a req/addr_ok/data_ok data-memory handshake and flush discard.
// Build option: MEM_ALIGN_CHECK_EN raises ALE on misaligned half/word accesses.
module mem_stage_hs
    import mem_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                cancel,
    input  logic                exe_to_mem_valid,
    output logic                mem_allowin,
    input  logic [DATA_W-1:0]   exe_pc,
    input  logic [DATA_W-1:0]   exe_result,
    input  logic [OP_W-1:0]     exe_mem_op,
    input  logic                exe_res_from_mem,
    input  logic [DATA_W-1:0]   exe_st_data,
    input  logic [RF_ALL_W-1:0] exe_rf_all,
    input  logic [CSR_W-1:0]    exe_csr_rf,
    input  logic [EXC_W-1:0]    exe_exc_rf,
    output logic                mem_to_wb_valid,
    input  logic                wb_allowin,
    output logic [DATA_W-1:0]   mem_pc,
    output logic [MEM_RF_W-1:0] mem_rf_all,
    output logic [CSR_W-1:0]    mem_csr_rf,
    output logic [EXC_W-1:0]    mem_exc_rf,
    output logic                data_req,
    output logic                data_wr,
    output logic [1:0]          data_size,
    output logic [3:0]          data_wstrb,
    output logic [DATA_W-1:0]   data_addr,
    output logic [DATA_W-1:0]   data_wdata,
    input  logic                data_addr_ok,
    input  logic                data_data_ok,
    input  logic [DATA_W-1:0]   data_rdata
);

    state_e              r_state;
    logic                r_mem_valid;
    logic [CNT_W-1:0]    r_discard_cnt;
    logic [DATA_W-1:0]   r_pc;
    logic [DATA_W-1:0]   r_result;
    logic [DATA_W-1:0]   r_st_data;
    logic [DATA_W-1:0]   r_ld_data;
    logic [OP_W-1:0]     r_op;
    logic                r_res_from_mem;
    logic                r_rf_we;
    logic [4:0]          r_rf_waddr;
    logic [CSR_W-1:0]    r_csr;
    logic [EXC_W-1:0]    r_exc;

    logic                w_allowin;
    logic                w_capture;
    logic                w_req;
    logic                w_drop;
    logic                w_resp;
    logic                w_inc;
    logic [EXC_W-1:0]    w_cap_exc;
    logic                w_cap_rf_we;
    state_e              w_cap_state;
    logic [DATA_W-1:0]   w_ld_aligned;
    size_e               w_size;

    assign w_allowin = ~r_mem_valid | ((r_state == DONE) & wb_allowin);
    assign w_capture = exe_to_mem_valid & w_allowin;
    assign w_req     = (r_state == REQ) & (r_discard_cnt != CNT_W'(DISCARD_MAX));
    assign w_drop    = data_data_ok & (r_discard_cnt != '0);
    assign w_resp    = data_data_ok & ~w_drop & (r_state == WAIT);
    // A flushed request still owes a response unless that response lands this very cycle.
    assign w_inc     = cancel & (((r_state == WAIT) & ~w_resp) | (w_req & data_addr_ok));

    always_comb begin
        w_cap_exc   = exe_exc_rf;
        w_cap_rf_we = exe_rf_all[RF_ALL_W-1];
`ifdef MEM_ALIGN_CHECK_EN
        if (((exe_mem_op[OP_LD_H] | exe_mem_op[OP_ST_H]) & exe_result[0]) |
            ((exe_mem_op[OP_LD_W] | exe_mem_op[OP_ST_W]) & (exe_result[1:0] != 2'b00))) begin
            w_cap_exc[ALE_BIT] = 1'b1;
            w_cap_rf_we        = 1'b0;
        end
`endif
        w_cap_state = ((exe_mem_op[OP_WE] | exe_res_from_mem) & (w_cap_exc == '0)) ? REQ : DONE;
    end

    // Control state, valid and discard bookkeeping
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_mem_valid   <= 1'b0;
            r_state       <= IDLE;
            r_discard_cnt <= '0;
            r_rf_we       <= 1'b0;
            r_exc         <= '0;
        end else begin
            case ({w_inc, w_drop})
                2'b10:   r_discard_cnt <= r_discard_cnt + CNT_W'(1);
                2'b01:   r_discard_cnt <= r_discard_cnt - CNT_W'(1);
                default: r_discard_cnt <= r_discard_cnt;
            endcase

            if (cancel) begin
                r_mem_valid <= 1'b0;
                r_state     <= IDLE;
            end else if (w_capture) begin
                r_mem_valid <= 1'b1;
                r_state     <= w_cap_state;
                r_rf_we     <= w_cap_rf_we;
                r_exc       <= w_cap_exc;
            end else begin
                case (r_state)
                    REQ:  if (w_req & data_addr_ok) r_state <= WAIT;
                    WAIT: if (w_resp) r_state <= DONE;
                    DONE: if (wb_allowin) begin
                        r_mem_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    // Payload registers need no reset; they are qualified by r_mem_valid
    always_ff @(posedge clk) begin
        if (w_capture & ~cancel) begin
            r_pc           <= exe_pc;
            r_result       <= exe_result;
            r_op           <= exe_mem_op;
            r_res_from_mem <= exe_res_from_mem;
            r_st_data      <= exe_st_data;
            r_rf_waddr     <= exe_rf_all[4:0];
            r_csr          <= exe_csr_rf;
        end
        if (w_resp & r_res_from_mem)
            r_ld_data <= w_ld_aligned;
    end

    mem_load_align u_load_align (
        .i_rdata   (data_rdata),
        .i_addr_lo (r_result[1:0]),
        .i_ld_b    (r_op[OP_LD_B]),
        .i_ld_h    (r_op[OP_LD_H]),
        .i_ld_w    (r_op[OP_LD_W]),
        .i_ld_se   (r_op[OP_LD_SE]),
        .o_data    (w_ld_aligned)
    );

    assign w_size = op_size(r_op);

    always_comb begin
        data_wstrb = 4'b1111;
        data_wdata = r_st_data;
        case (w_size)
            SIZE_B: begin
                data_wstrb = 4'b0001 << r_result[1:0];
                data_wdata = {4{r_st_data[7:0]}};
            end
            SIZE_H: begin
                data_wstrb = r_result[1] ? 4'b1100 : 4'b0011;
                data_wdata = {2{r_st_data[15:0]}};
            end
            default: begin
                data_wstrb = 4'b1111;
                data_wdata = r_st_data;
            end
        endcase
    end

    assign mem_allowin     = w_allowin;
    assign mem_to_wb_valid = r_mem_valid & (r_state == DONE);
    assign data_req        = w_req;
    assign data_wr         = r_op[OP_WE];
    assign data_size       = w_size;
    assign data_addr       = r_result;
    assign mem_pc          = r_pc;
    assign mem_rf_all      = {r_rf_we, r_rf_waddr, r_res_from_mem ? r_ld_data : r_result};
    assign mem_csr_rf      = r_csr;
    assign mem_exc_rf      = r_exc;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed self-checking bench for mem_stage_hs; honours MEM_ALIGN_CHECK_EN.
module tb_mem_stage_hs;
    import mem_pkg::*;

    logic                clk = 1'b0;
    logic                resetn, cancel, exe_to_mem_valid, mem_allowin;
    logic [31:0]         exe_pc, exe_result, exe_st_data;
    logic [7:0]          exe_mem_op;
    logic                exe_res_from_mem;
    logic [5:0]          exe_rf_all;
    logic [CSR_W-1:0]    exe_csr_rf;
    logic [EXC_W-1:0]    exe_exc_rf;
    logic                mem_to_wb_valid, wb_allowin;
    logic [31:0]         mem_pc;
    logic [37:0]         mem_rf_all;
    logic [CSR_W-1:0]    mem_csr_rf;
    logic [EXC_W-1:0]    mem_exc_rf;
    logic                data_req, data_wr;
    logic [1:0]          data_size;
    logic [3:0]          data_wstrb;
    logic [31:0]         data_addr, data_wdata, data_rdata;
    logic                data_addr_ok, data_data_ok;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [7:0] OP_LDB_SE = 8'h48;
    localparam logic [7:0] OP_LDH    = 8'h20;
    localparam logic [7:0] OP_LDW    = 8'h10;
    localparam logic [7:0] OP_STB    = 8'h84;
    localparam logic [7:0] OP_STH    = 8'h82;
    localparam logic [7:0] OP_STW    = 8'h81;

    always #5 clk = ~clk;

    mem_stage_hs dut (
        .clk(clk), .resetn(resetn), .cancel(cancel),
        .exe_to_mem_valid(exe_to_mem_valid), .mem_allowin(mem_allowin),
        .exe_pc(exe_pc), .exe_result(exe_result), .exe_mem_op(exe_mem_op),
        .exe_res_from_mem(exe_res_from_mem), .exe_st_data(exe_st_data),
        .exe_rf_all(exe_rf_all), .exe_csr_rf(exe_csr_rf), .exe_exc_rf(exe_exc_rf),
        .mem_to_wb_valid(mem_to_wb_valid), .wb_allowin(wb_allowin),
        .mem_pc(mem_pc), .mem_rf_all(mem_rf_all), .mem_csr_rf(mem_csr_rf),
        .mem_exc_rf(mem_exc_rf), .data_req(data_req), .data_wr(data_wr),
        .data_size(data_size), .data_wstrb(data_wstrb), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    task automatic chk_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_exe(input logic [31:0] pc, input logic [31:0] addr, input logic [7:0] op,
                             input logic [31:0] st, input logic [5:0] rf, input logic [EXC_W-1:0] exc);
        exe_to_mem_valid = 1'b1;
        exe_pc           = pc;
        exe_result       = addr;
        exe_mem_op       = op;
        exe_res_from_mem = ~op[7] & (op[6] | op[5] | op[4]);
        exe_st_data      = st;
        exe_rf_all       = rf;
        exe_csr_rf       = {CSR_W{1'b0}} | {pc, pc};
        exe_exc_rf       = exc;
        #1;
    endtask

    function automatic logic [37:0] rf_exp(input logic we, input logic [4:0] wa, input logic [31:0] d);
        return {we, wa, d};
    endfunction

    initial begin
        resetn = 1'b0; cancel = 1'b0; exe_to_mem_valid = 1'b0; wb_allowin = 1'b1;
        exe_pc = '0; exe_result = '0; exe_mem_op = '0; exe_res_from_mem = 1'b0;
        exe_st_data = '0; exe_rf_all = '0; exe_csr_rf = '0; exe_exc_rf = '0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
        repeat (3) tick();
        chk_eq("rst_valid", 128'(mem_to_wb_valid), 128'd0);
        chk_eq("rst_req", 128'(data_req), 128'd0);
        chk_eq("rst_allowin", 128'(mem_allowin), 128'd1);
        chk_eq("rst_rf_we", 128'(mem_rf_all[37]), 128'd0);
        chk_eq("rst_exc", 128'(mem_exc_rf), 128'd0);
        resetn = 1'b1;
        tick();

        // ld.b sign-extended at 0x1003, response three cycles after addr_ok
        drive_exe(32'h1c00_0000, 32'h0000_1003, OP_LDB_SE, 32'h0, 6'b1_00101, '0);
        tick();
        exe_to_mem_valid = 1'b0;
        chk_eq("ldb_req", 128'(data_req), 128'd1);
        chk_eq("ldb_wr", 128'(data_wr), 128'd0);
        chk_eq("ldb_size", 128'(data_size), 128'd0);
        chk_eq("ldb_addr", 128'(data_addr), 128'h1003);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        chk_eq("ldb_req_drop", 128'(data_req), 128'd0);
        repeat (2) tick();
        data_data_ok = 1'b1; data_rdata = 32'h80FF_1234;
        #1;
        chk_eq("ldb_not_yet", 128'(mem_to_wb_valid), 128'd0);
        tick();
        data_data_ok = 1'b0; data_rdata = '0;
        chk_eq("ldb_valid", 128'(mem_to_wb_valid), 128'd1);
        chk_eq("ldb_rf", 128'(mem_rf_all), 128'(rf_exp(1'b1, 5'd5, 32'hFFFF_FF80)));
        chk_eq("ldb_pc", 128'(mem_pc), 128'h1c00_0000);
        chk_eq("ldb_csr", 128'(mem_csr_rf), 128'h1c00_0000_1c00_0000);
        tick();
        chk_eq("ldb_retire", 128'(mem_to_wb_valid), 128'd0);

        // st.h of 0xABCD to 0x2002
        drive_exe(32'h1c00_0004, 32'h0000_2002, OP_STH, 32'h0000_ABCD, 6'b0, '0);
        tick();
        exe_to_mem_valid = 1'b0;
        chk_eq("sth_req", 128'(data_req), 128'd1);
        chk_eq("sth_wr", 128'(data_wr), 128'd1);
        chk_eq("sth_size", 128'(data_size), 128'd1);
        chk_eq("sth_wstrb", 128'(data_wstrb), 128'b1100);
        chk_eq("sth_wdata", 128'(data_wdata), 128'hABCD_ABCD);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        chk_eq("sth_wait", 128'(mem_to_wb_valid), 128'd0);
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        chk_eq("sth_done", 128'(mem_to_wb_valid), 128'd1);
        chk_eq("sth_rf_we", 128'(mem_rf_all[37]), 128'd0);
        tick();

        // st.b of 0xEF to 0x5001
        drive_exe(32'h1c00_0008, 32'h0000_5001, OP_STB, 32'h1234_56EF, 6'b0, '0);
        tick();
        exe_to_mem_valid = 1'b0;
        chk_eq("stb_wstrb", 128'(data_wstrb), 128'b0010);
        chk_eq("stb_wdata", 128'(data_wdata), 128'hEFEF_EFEF);
        data_addr_ok = 1'b1; tick(); data_addr_ok = 1'b0;
        data_data_ok = 1'b1; tick(); data_data_ok = 1'b0;
        chk_eq("stb_done", 128'(mem_to_wb_valid), 128'd1);
        tick();

        // Cancel in WAIT; the stale response must be dropped
        drive_exe(32'h1c00_0010, 32'h0000_3000, OP_LDW, 32'h0, 6'b1_00110, '0);
        tick();
        exe_to_mem_valid = 1'b0;
        data_addr_ok = 1'b1; tick(); data_addr_ok = 1'b0;
        cancel = 1'b1; tick(); cancel = 1'b0;
        chk_eq("cxl_valid", 128'(mem_to_wb_valid), 128'd0);
        chk_eq("cxl_allowin", 128'(mem_allowin), 128'd1);
        drive_exe(32'h1c00_0014, 32'h0000_3004, OP_LDW, 32'h0, 6'b1_00111, '0);
        tick();
        exe_to_mem_valid = 1'b0;
        chk_eq("cxl_req", 128'(data_req), 128'd1);
        data_addr_ok = 1'b1; tick(); data_addr_ok = 1'b0;
        data_data_ok = 1'b1; data_rdata = 32'h0000_DEAD; tick();
        chk_eq("cxl_dropped", 128'(mem_to_wb_valid), 128'd0);
        data_rdata = 32'h0000_1234; tick();
        data_data_ok = 1'b0;
        chk_eq("cxl_valid2", 128'(mem_to_wb_valid), 128'd1);
        chk_eq("cxl_rf", 128'(mem_rf_all), 128'(rf_exp(1'b1, 5'd7, 32'h0000_1234)));
        tick();

        // Three flushes (first one in REQ with addr_ok) saturate the discard counter
        for (int i = 0; i < 3; i++) begin
            drive_exe(32'h1c00_0020 + 32'(i * 4), 32'h0000_6000, OP_LDW, 32'h0, 6'b1_00001, '0);
            tick();
            exe_to_mem_valid = 1'b0;
            if (i == 0) begin
                data_addr_ok = 1'b1; cancel = 1'b1; tick();
            end else begin
                data_addr_ok = 1'b1; tick(); data_addr_ok = 1'b0;
                cancel = 1'b1; tick();
            end
            data_addr_ok = 1'b0; cancel = 1'b0;
        end
        drive_exe(32'h1c00_0030, 32'h0000_6004, OP_LDW, 32'h0, 6'b1_01000, '0);
        tick();
        exe_to_mem_valid = 1'b0;
        chk_eq("sat_req0", 128'(data_req), 128'd0);
        tick();
        chk_eq("sat_req1", 128'(data_req), 128'd0);
        chk_eq("sat_allowin", 128'(mem_allowin), 128'd0);
        data_data_ok = 1'b1; tick(); data_data_ok = 1'b0;
        chk_eq("sat_req_resume", 128'(data_req), 128'd1);
        data_addr_ok = 1'b1; tick(); data_addr_ok = 1'b0;
        data_data_ok = 1'b1; data_rdata = 32'hFFFF_0000; tick();
        tick();
        chk_eq("sat_drop2", 128'(mem_to_wb_valid), 128'd0);
        data_rdata = 32'h5555_AAAA; tick();
        data_data_ok = 1'b0;
        chk_eq("sat_valid", 128'(mem_to_wb_valid), 128'd1);
        chk_eq("sat_rf", 128'(mem_rf_all), 128'(rf_exp(1'b1, 5'd8, 32'h5555_AAAA)));
        tick();

        // WB back-pressure holds the stage; release captures the next op in the same cycle
        drive_exe(32'h1c00_0040, 32'h0000_4002, OP_LDH, 32'h0, 6'b1_01001, '0);
        tick();
        exe_to_mem_valid = 1'b0;
        wb_allowin = 1'b0;
        data_addr_ok = 1'b1; tick(); data_addr_ok = 1'b0;
        data_data_ok = 1'b1; data_rdata = 32'h8765_4321; tick();
        data_data_ok = 1'b0;
        drive_exe(32'h1c00_0044, 32'h0000_5008, OP_STW, 32'hCAFE_F00D, 6'b0, '0);
        chk_eq("bp_allowin", 128'(mem_allowin), 128'd0);
        tick(); tick();
        chk_eq("bp_valid", 128'(mem_to_wb_valid), 128'd1);
        chk_eq("bp_rf", 128'(mem_rf_all), 128'(rf_exp(1'b1, 5'd9, 32'h0000_8765)));
        chk_eq("bp_pc", 128'(mem_pc), 128'h1c00_0040);
        wb_allowin = 1'b1;
        #1;
        chk_eq("bp_release", 128'(mem_allowin), 128'd1);
        tick();
        exe_to_mem_valid = 1'b0;
        chk_eq("b2b_pc", 128'(mem_pc), 128'h1c00_0044);
        chk_eq("b2b_req", 128'(data_req), 128'd1);
        chk_eq("b2b_wstrb", 128'(data_wstrb), 128'b1111);
        chk_eq("b2b_wdata", 128'(data_wdata), 128'hCAFE_F00D);
        chk_eq("b2b_size", 128'(data_size), 128'd2);
        data_addr_ok = 1'b1; tick(); data_addr_ok = 1'b0;
        data_data_ok = 1'b1; tick(); data_data_ok = 1'b0;
        tick();

        // Incoming exception skips the memory request
        drive_exe(32'h1c00_0050, 32'h0000_7000, OP_LDW, 32'h0, 6'b1_01010, EXC_W'(1));
        tick();
        exe_to_mem_valid = 1'b0;
        chk_eq("exc_req", 128'(data_req), 128'd0);
        chk_eq("exc_valid", 128'(mem_to_wb_valid), 128'd1);
        chk_eq("exc_flags", 128'(mem_exc_rf), 128'd1);
        tick();

        // Misaligned ld.w at 0x1002
        drive_exe(32'h1c00_0060, 32'h0000_1002, OP_LDW, 32'h0, 6'b1_01011, '0);
        tick();
        exe_to_mem_valid = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        chk_eq("ale_req", 128'(data_req), 128'd0);
        chk_eq("ale_valid", 128'(mem_to_wb_valid), 128'd1);
        chk_eq("ale_bit", 128'(mem_exc_rf[ALE_BIT]), 128'd1);
        chk_eq("ale_rf_we", 128'(mem_rf_all[37]), 128'd0);
        tick();
`else
        chk_eq("mis_req", 128'(data_req), 128'd1);
        chk_eq("mis_addr", 128'(data_addr), 128'h1002);
        data_addr_ok = 1'b1; tick(); data_addr_ok = 1'b0;
        data_data_ok = 1'b1; data_rdata = 32'h0BAD_F00D; tick(); data_data_ok = 1'b0;
        chk_eq("mis_rf", 128'(mem_rf_all), 128'(rf_exp(1'b1, 5'd11, 32'h0BAD_F00D)));
        chk_eq("mis_exc", 128'(mem_exc_rf), 128'd0);
        tick();
`endif

        // Reset mid-flush clears the discard counter
        drive_exe(32'h1c00_0070, 32'h0000_8000, OP_LDW, 32'h0, 6'b1_01100, '0);
        tick();
        exe_to_mem_valid = 1'b0;
        data_addr_ok = 1'b1; tick(); data_addr_ok = 1'b0;
        cancel = 1'b1; tick(); cancel = 1'b0;
        resetn = 1'b0; tick(); resetn = 1'b1;
        drive_exe(32'h1c00_0074, 32'h0000_8004, OP_LDW, 32'h0, 6'b1_01101, '0);
        tick();
        exe_to_mem_valid = 1'b0;
        data_addr_ok = 1'b1; tick(); data_addr_ok = 1'b0;
        data_data_ok = 1'b1; data_rdata = 32'h0000_00AB; tick(); data_data_ok = 1'b0;
        chk_eq("rst_cnt_valid", 128'(mem_to_wb_valid), 128'd1);
        chk_eq("rst_cnt_rf", 128'(mem_rf_all), 128'(rf_exp(1'b1, 5'd13, 32'h0000_00AB)));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
